// File: rtl/mips_mem_sequencer_pkg.sv
// Shared definitions for the multicycle memory sequencer: state encoding,
// datapath width and the instruction word loaded into IR at reset.
package mips_mem_sequencer_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_FETCH = 3'd1,
      SEQ_EXEC  = 3'd2,
      SEQ_MEM   = 3'd3,
      SEQ_WB    = 3'd4,
      SEQ_ERR   = 3'd5
   } seq_state_t;

   // sll $0,$0,0 -- an all-zero word is a MIPS nop
   localparam logic [DATA_W-1:0] NOP_INSN = '0;

endpackage

// File: rtl/seq_timeout.sv
// Wait-cycle counter for the shared memory port: flags the cycle in which the
// TIMEOUT-th consecutive unanswered request cycle is being spent.
module seq_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic wait_en,
   output logic expired
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (wait_en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // This wait cycle is the TIMEOUT-th one; a ready in the same cycle keeps wait_en low.
   assign expired = wait_en && (cnt == LAST);

endmodule

// File: rtl/mips_mem_sequencer.sv
// Multicycle sequencer running the mips_cpu datapath from one shared,
// variable-latency memory port: FETCH -> EXEC -> [MEM] -> WB per instruction.
module mips_mem_sequencer
   import mips_mem_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] imem_a,
   output logic [DATA_W-1:0] imem_rd,
   input  logic [DATA_W-1:0] dmem_a,
   input  logic [DATA_W-1:0] dmem_wd,
   input  logic              dmem_we,
   input  logic              dmem_re,
   output logic [DATA_W-1:0] dmem_rd,
   output logic              pc_en,
   output logic              rf_we_en,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [DATA_W-1:0] retired,
   output logic              bus_err
);

   seq_state_t        state, state_nxt;
   logic [DATA_W-1:0] ir_q, mdr_q, retired_q;
   logic              acc_we_q, acc_re_q;
   logic              in_fetch, in_mem, expired;

   assign in_fetch = (state == SEQ_FETCH);
   assign in_mem   = (state == SEQ_MEM);

   seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!(in_fetch || in_mem)),
      .wait_en (mem_req && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEQ_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         SEQ_IDLE:  state_nxt = SEQ_FETCH;
         SEQ_FETCH: begin
            if (mem_ready)    state_nxt = SEQ_EXEC;
            else if (expired) state_nxt = SEQ_ERR;
         end
         SEQ_EXEC:  state_nxt = (dmem_we || dmem_re) ? SEQ_MEM : SEQ_WB;
         SEQ_MEM: begin
            if (mem_ready)    state_nxt = SEQ_WB;
            else if (expired) state_nxt = SEQ_ERR;
         end
         SEQ_WB:    state_nxt = SEQ_FETCH;
         SEQ_ERR:   state_nxt = SEQ_ERR;
         default:   state_nxt = SEQ_IDLE;
      endcase
   end

   // Access kind is latched leaving EXEC so mem_we is a pure state decode; store wins over load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q      <= NOP_INSN;
         mdr_q     <= '0;
         retired_q <= '0;
         acc_we_q  <= 1'b0;
         acc_re_q  <= 1'b0;
      end else begin
         if (in_fetch && mem_ready) ir_q <= mem_rd;
         if (in_mem && mem_ready && acc_re_q && !acc_we_q) mdr_q <= mdr_q ^ mdr_q ^ mem_rd;
         if (state == SEQ_EXEC) begin
            acc_we_q <= dmem_we;
            acc_re_q <= dmem_re;
         end
         if (state == SEQ_WB) retired_q <= retired_q + DATA_W'(1);
      end
   end

   assign mem_req  = in_fetch || in_mem;
   assign mem_a    = in_mem ? dmem_a : imem_a;
   assign mem_wd   = in_mem ? dmem_wd : '0;
   assign mem_we   = in_mem && acc_we_q;
   assign pc_en    = (state == SEQ_WB);
   assign rf_we_en = (state == SEQ_WB);
   assign bus_err  = (state == SEQ_ERR);
   assign imem_rd  = ir_q;
   assign dmem_rd  = mdr_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Directed bench for mips_mem_sequencer: fetch/exec/wb, store and load with
// waits, reset mid-access, retired wrap and bus timeout.
module tb_mips_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_a, imem_rd, dmem_a, dmem_wd, dmem_rd;
   logic        dmem_we, dmem_re, pc_en, rf_we_en, mem_req, mem_we, mem_ready;
   logic [31:0] mem_a, mem_wd, mem_rd, retired;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;

   always #5 clk = ~clk;

   mips_mem_sequencer #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem_a    (imem_a),
      .imem_rd   (imem_rd),
      .dmem_a    (dmem_a),
      .dmem_wd   (dmem_wd),
      .dmem_we   (dmem_we),
      .dmem_re   (dmem_re),
      .dmem_rd   (dmem_rd),
      .pc_en     (pc_en),
      .rf_we_en  (rf_we_en),
      .mem_req   (mem_req),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .retired   (retired),
      .bus_err   (bus_err)
   );

   always @(posedge clk) begin
      if (mem_req && mem_we && mem_ready) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; imem_a = '0; dmem_a = '0; dmem_wd = '0;
      dmem_we = 1'b0; dmem_re = 1'b0; mem_ready = 1'b0; mem_rd = '0;
      tick(); tick();
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_pc_en", {31'b0, pc_en}, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_bus_err", {31'b0, bus_err}, 32'd0);
      check("rst_ir", imem_rd, 32'h0);
      check("rst_mdr", dmem_rd, 32'h0);

      // add at 0x0, zero-wait memory
      rst_n = 1'b1;
      #1 check("idle_no_req", {31'b0, mem_req}, 32'd0);
      tick();
      check("fetch_req", {31'b0, mem_req}, 32'd1);
      check("fetch_addr", mem_a, 32'h0);
      check("fetch_we", {31'b0, mem_we}, 32'd0);
      mem_ready = 1'b1; mem_rd = 32'h014B4820;
      tick();
      check("exec_no_req", {31'b0, mem_req}, 32'd0);
      check("exec_ir", imem_rd, 32'h014B4820);
      check("exec_pc_en", {31'b0, pc_en}, 32'd0);
      tick();
      check("wb_pc_en", {31'b0, pc_en}, 32'd1);
      check("wb_rf_we", {31'b0, rf_we_en}, 32'd1);
      check("wb_no_req", {31'b0, mem_req}, 32'd0);
      tick();
      check("add_pc_en_off", {31'b0, pc_en}, 32'd0);
      check("add_retired", retired, 32'd1);
      check("fetch2_req", {31'b0, mem_req}, 32'd1);

      // sw to 0x40 with two wait cycles in MEM
      imem_a = 32'h4; mem_rd = 32'hAC0A0040;
      tick();
      check("sw_ir", imem_rd, 32'hAC0A0040);
      dmem_we = 1'b1; dmem_a = 32'h40; dmem_wd = 32'hDEADBEEF; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) mem_ready = 1'b1;
         check("sw_req", {31'b0, mem_req}, 32'd1);
         check("sw_we", {31'b0, mem_we}, 32'd1);
         check("sw_addr", mem_a, 32'h40);
         check("sw_data", mem_wd, 32'hDEADBEEF);
      end
      tick();
      dmem_we = 1'b0;
      check("sw_wb_pc_en", {31'b0, pc_en}, 32'd1);
      check("sw_wb_no_req", {31'b0, mem_req}, 32'd0);
      check("sw_mdr_kept", dmem_rd, 32'h0);
      check("sw_one_write", wr_cnt, 32'd1);
      tick();
      check("sw_retired", retired, 32'd2);

      // lw from 0x44, one wait cycle: five-cycle instruction
      imem_a = 32'h8; mem_rd = 32'h8C0B0044;
      tick();
      dmem_re = 1'b1; dmem_a = 32'h44; mem_ready = 1'b0; mem_rd = 32'hBAD0BAD0;
      tick();
      check("lw_req", {31'b0, mem_req}, 32'd1);
      check("lw_we", {31'b0, mem_we}, 32'd0);
      check("lw_addr", mem_a, 32'h44);
      tick();
      check("lw_wait_pc_en", {31'b0, pc_en}, 32'd0);
      check("lw_mdr_wait", dmem_rd, 32'h0);
      mem_ready = 1'b1; mem_rd = 32'h12345678;
      tick();
      dmem_re = 1'b0;
      check("lw_wb_pc_en", {31'b0, pc_en}, 32'd1);
      check("lw_mdr", dmem_rd, 32'h12345678);
      tick();
      check("lw_retired", retired, 32'd3);
      check("lw_one_write_total", wr_cnt, 32'd1);

      // reset asserted in the middle of a MEM wait
      mem_rd = 32'h8C0B0048;
      tick();
      dmem_re = 1'b1; mem_ready = 1'b0;
      tick();
      check("pre_rst_req", {31'b0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'b0, mem_req}, 32'd0);
      check("mid_rst_ir", imem_rd, 32'h0);
      check("mid_rst_mdr", dmem_rd, 32'h0);
      check("mid_rst_retired", retired, 32'd0);
      dmem_re = 1'b0;
      tick();
      rst_n = 1'b1;
      #1 check("rel_idle_req", {31'b0, mem_req}, 32'd0);
      tick();
      check("rel_fetch_req", {31'b0, mem_req}, 32'd1);

      // retired wraps from 0xFFFFFFFF
      force dut.retired_q = 32'hFFFFFFFF;
      #1 release dut.retired_q;
      #1 check("preset_retired", retired, 32'hFFFFFFFF);
      mem_ready = 1'b1; mem_rd = 32'h014B4820;
      tick(); tick(); tick();
      check("wrap_retired", retired, 32'd0);

      // memory never answers in FETCH: ERR after four wait cycles
      mem_ready = 1'b0;
      tick(); tick(); tick();
      check("to_w4_req", {31'b0, mem_req}, 32'd1);
      check("to_w4_err", {31'b0, bus_err}, 32'd0);
      tick();
      check("to_bus_err", {31'b0, bus_err}, 32'd1);
      check("to_no_req", {31'b0, mem_req}, 32'd0);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("err_no_req", {31'b0, mem_req}, 32'd0);
         check("err_no_pc_en", {31'b0, pc_en}, 32'd0);
         check("err_sticky", {31'b0, bus_err}, 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
